// File: rtl/line_buffer_feeder.sv
// Frame reader feeding the 3x3 line buffer: fetches input_x*input_y pixels from a
// 1-cycle-latency RAM and streams them under busy back-pressure via a 2-entry skid FIFO.
module line_buffer_feeder #(
  parameter int data_width = 16,
  parameter int input_y    = 3,
  parameter int input_x    = 3,
  parameter int addr_width = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [addr_width-1:0] base_addr,
  output logic                  rd_en,
  output logic [addr_width-1:0] rd_addr,
  input  logic [data_width-1:0] rd_data,
  input  logic                  busy,
  output logic                  output_valid,
  output logic                  sof,
  output logic [data_width-1:0] data_out,
  output logic                  done,
  output logic                  streaming,
  output logic [7:0]            x,
  output logic [7:0]            y
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int         total     = input_x * input_y;
  localparam logic [15:0] last_idx = 16'(total - 1);
  localparam logic [7:0]  last_x   = 8'(input_x - 1);

  logic [1:0]            state;
  logic [addr_width-1:0] base_q;
  logic [15:0]           issue_idx;
  logic                  inflight;

  logic [data_width-1:0] fifo_mem [2];
  logic                  fifo_wr_ptr;
  logic                  fifo_rd_ptr;
  logic [1:0]            fifo_count;
  logic [1:0]            fifo_count_next;
  logic                  push;
  logic                  pop;

  // Handshake: a pixel transfers on every cycle output_valid is high; the line
  // buffer refuses pixels by raising busy, which combinationally drops output_valid.
  assign output_valid = !busy && (fifo_count != 2'd0);
  assign pop          = output_valid;
  assign push         = inflight;
  assign data_out     = output_valid ? fifo_mem[fifo_rd_ptr] : '0;
  assign sof          = output_valid && (x == 8'd0) && (y == 8'd0);
  assign done         = (state == S_DONE);
  assign streaming    = (state != S_IDLE);

  // Reads already in flight count against FIFO space so the FIFO never overflows.
  assign rd_en   = (state == S_READ) &&
                   (((fifo_count + {1'b0, inflight}) < 2'd2) || pop);
  assign rd_addr = rd_en ? (base_q + addr_width'(issue_idx)) : '0;

  assign fifo_count_next = 2'(fifo_count + {1'b0, push} - {1'b0, pop});

  always_ff @(posedge clk) begin
    if (!rst) begin
      fifo_wr_ptr <= 1'b0;
      fifo_rd_ptr <= 1'b0;
      fifo_count  <= 2'd0;
      inflight    <= 1'b0;
    end else begin
      inflight   <= rd_en;
      fifo_count <= fifo_count_next;
      if (push) begin
        fifo_mem[fifo_wr_ptr] <= rd_data;
        fifo_wr_ptr           <= !fifo_wr_ptr;
      end
      if (pop) fifo_rd_ptr <= !fifo_rd_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      base_q    <= '0;
      issue_idx <= '0;
      x         <= '0;
      y         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            base_q    <= base_addr;
            issue_idx <= '0;
            state     <= S_READ;
          end
        end
        S_READ: begin
          if (rd_en) begin
            issue_idx <= issue_idx + 16'd1;
            if (issue_idx == last_idx) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (fifo_count_next == 2'd0) state <= S_DONE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase

      if (state == S_DONE) begin
        x <= '0;
        y <= '0;
      end else if (pop) begin
        if (x == last_x) begin
          x <= '0;
          y <= y + 8'd1;
        end else begin
          x <= x + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_line_buffer_feeder.sv
// Bench for line_buffer_feeder: RAM model, frame driver, and a scoreboard monitor
// comparing every read address and presented pixel against per-frame expectations.
module tb_line_buffer_feeder;
  localparam int DW    = 16;
  localparam int AW    = 16;
  localparam int X     = 3;
  localparam int Y     = 3;
  localparam int N     = X * Y;
  localparam int EXP_W = 1 + 8 + 8 + DW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic          busy = 1'b0;
  logic          output_valid;
  logic          sof;
  logic [DW-1:0] data_out;
  logic          done;
  logic          streaming;
  logic [7:0]    x;
  logic [7:0]    y;

  line_buffer_feeder #(.data_width(DW), .input_y(Y), .input_x(X), .addr_width(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy),
    .output_valid(output_valid), .sof(sof), .data_out(data_out), .done(done),
    .streaming(streaming), .x(x), .y(y)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] mem [0:65535];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard state
  logic [EXP_W-1:0] exp_q[$];
  logic [AW-1:0]    addr_q[$];
  int start_cyc = 0;
  int n_reads, n_valid, n_done, first_rd, last_rd, first_v, last_v, done_cyc, max_out;

  always @(negedge clk) begin
    automatic int rel = cyc - start_cyc;
    automatic logic [EXP_W-1:0] e;
    automatic logic [AW-1:0] a;
    if (start && !streaming && rst) begin
      n_reads = 0; n_valid = 0; n_done = 0; max_out = 0;
      first_rd = -1; last_rd = -1; first_v = -1; last_v = -1; done_cyc = -1;
    end
    if (rd_en === 1'b1) begin
      n_reads++;
      if (first_rd < 0) first_rd = rel;
      last_rd = rel;
      if (addr_q.size() == 0) check("extra_read", 64'(rd_addr), 64'hDEAD);
      else begin
        a = addr_q.pop_front();
        check("rd_addr", 64'(rd_addr), 64'(a));
      end
    end
    if (busy === 1'b1 && output_valid === 1'b1) check("valid_while_busy", 1, 0);
    if (output_valid === 1'b1) begin
      n_valid++;
      if (first_v < 0) first_v = rel;
      last_v = rel;
      if (exp_q.size() == 0) check("unexpected_pixel", 64'(data_out), 64'hDEAD);
      else begin
        e = exp_q.pop_front();
        check("data_out", 64'(data_out), 64'(e[DW-1:0]));
        check("sof", 64'(sof), 64'(e[EXP_W-1]));
        check("x", 64'(x), 64'(e[EXP_W-2 -: 8]));
        check("y", 64'(y), 64'(e[EXP_W-10 -: 8]));
      end
    end
    if (n_reads - n_valid > max_out) max_out = n_reads - n_valid;
    if (done === 1'b1) begin
      n_done++;
      done_cyc = rel;
      check("done_queue_empty", 64'(exp_q.size() + addr_q.size()), 0);
    end
    if (rst === 1'b0) begin
      exp_q.delete();
      addr_q.delete();
    end
  end

  // driver tasks
  task automatic push_frame(input logic [AW-1:0] base);
    for (int i = 0; i < N; i++) begin
      automatic logic [AW-1:0] a = base + AW'(i);
      addr_q.push_back(a);
      exp_q.push_back({(i == 0), 8'(i % X), 8'(i / X), mem[a]});
    end
  endtask

  task automatic issue_start(input logic [AW-1:0] base);
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = base;
    start_cyc = cyc;
  endtask

  // mode 0: busy low; 1: busy in cycles 5-7; 2: random busy; 3: start+base poke mid-frame
  task automatic run_frame(input logic [AW-1:0] base, input int mode);
    automatic bit finished = 0;
    push_frame(base);
    issue_start(base);
    for (int k = 1; k < 300 && !finished; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      case (mode)
        1: busy = (k >= 5 && k <= 7);
        2: busy = ($urandom_range(0, 3) == 0);
        3: begin
          start = (k == 4);
          if (k == 4) base_addr = 16'h1234;
        end
        default: busy = 1'b0;
      endcase
      if (done_cyc >= 0) finished = 1;
    end
    busy = 1'b0;
    if (!finished) check("frame_timeout", 0, 1);
    check("reads_per_frame", 64'(n_reads), 64'(N));
    check("pixels_per_frame", 64'(n_valid), 64'(N));
    check("done_pulses", 64'(n_done), 1);
    check("max_outstanding", 64'(max_out), 2);
    @(posedge clk); #1;
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    check({tag, "_rd_en"}, 64'(rd_en), 0);
    check({tag, "_rd_addr"}, 64'(rd_addr), 0);
    check({tag, "_valid"}, 64'(output_valid), 0);
    check({tag, "_sof"}, 64'(sof), 0);
    check({tag, "_data"}, 64'(data_out), 0);
    check({tag, "_done"}, 64'(done), 0);
    check({tag, "_streaming"}, 64'(streaming), 0);
    check({tag, "_x"}, 64'(x), 0);
    check({tag, "_y"}, 64'(y), 0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = DW'($urandom);
    for (int i = 0; i < N; i++) mem[i] = DW'(100 + i);

    // reset held with start high
    rst = 1'b0; start = 1'b1;
    @(posedge clk);
    check_idle("reset1");
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b0;
    check_idle("reset2");

    // nominal 3x3 frame timing
    run_frame(16'h0000, 0);
    check("t2_first_rd", 64'(first_rd), 1);
    check("t2_last_rd", 64'(last_rd), 9);
    check("t2_first_valid", 64'(first_v), 3);
    check("t2_last_valid", 64'(last_v), 11);
    check("t2_done_cycle", 64'(done_cyc), 12);

    // busy in cycles 5-7
    run_frame(16'h0000, 1);
    check("t3_last_rd", 64'(last_rd), 12);
    check("t3_last_valid", 64'(last_v), 14);
    check("t3_done_cycle", 64'(done_cyc), 15);

    // start pulse and base change mid-frame are ignored
    run_frame(16'h0020, 3);
    check("t4_done_cycle", 64'(done_cyc), 12);

    // reset mid-frame, then a clean frame
    push_frame(16'h0000);
    issue_start(16'h0000);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b0;
    check_idle("midreset");
    run_frame(16'h0000, 0);
    check("t5_first_valid", 64'(first_v), 3);
    check("t5_done_cycle", 64'(done_cyc), 12);

    // address wrap
    run_frame(16'hFFFE, 0);
    check("t6_done_cycle", 64'(done_cyc), 12);

    // randomized frames with random back-pressure
    for (int f = 0; f < 20; f++) run_frame(AW'($urandom), 2);

    check("final_queues_empty", 64'(exp_q.size() + addr_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
